gray_tx: RTL and testbench

GRAY_TX -- requirements
Module: gray_tx

---
 rtl/gray_tx_if.sv | 20 ++
 rtl/gray_tx.sv | 207 ++++++++++++++++++++
 tb/tb_gray_tx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/gray_tx_if.sv
// Handshake and status bundle between a Gray-code source and the gray_tx serializer.
interface gray_tx_if;
    logic [3:0] g_in;
    logic       g_valid;
    logic       g_ready;
    logic       tx;
    logic       busy;
    logic       step_err;
    logic [7:0] err_count;

    modport master (
        output g_in, g_valid,
        input  g_ready, tx, busy, step_err, err_count
    );

    modport slave (
        input  g_in, g_valid,
        output g_ready, tx, busy, step_err, err_count
    );
endinterface

// File: rtl/gray_tx.sv
// Serializes 4-bit Gray words (start, 4 data MSB-first, even parity, stop) through a
// 2-entry FIFO, and flags accepted words that are not a single-bit step from their predecessor.
module gray_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic     clk,
    input  logic     rst,
    gray_tx_if.slave bus
);
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       FIFO_DEPTH = 2'd2;
    localparam logic [1:0]       LAST_BIT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_fifo [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_count;
    logic [1:0]          w_count_nxt;
    logic [CNT_W-1:0]    r_clk_cnt;
    logic [1:0]          r_bit_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_parity;
    logic                r_tx;
    logic                r_busy;
    logic [DATA_W-1:0]   r_prev;
    logic                r_have_prev;
    logic                r_step_err;
    logic [7:0]          r_err_count;

    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_shift_en;
    logic                w_tx_nxt;
    logic                w_fifo_ne;
    logic                w_bit_done;
    logic [DATA_W-1:0]   w_head;
    logic [DATA_W-1:0]   w_diff;
    logic                w_unit_step;
    logic                w_step_bad;

    assign w_ready     = (r_count < FIFO_DEPTH);
    assign w_push      = bus.g_valid && w_ready;
    assign w_fifo_ne   = (r_count != 2'd0);
    assign w_bit_done  = (r_clk_cnt == CNT_MAX);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);

    // Unit Gray step: exactly one bit differs (non-zero power of two).
    assign w_diff      = bus.g_in ^ r_prev;
    assign w_unit_step = (w_diff != '0) && ((w_diff & (w_diff - DATA_W'(1))) == '0);
    assign w_step_bad  = w_push && r_have_prev && !w_unit_step;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_fifo_ne) w_state_nxt = S_START;
            S_START:  if (w_bit_done) w_state_nxt = S_DATA;
            S_DATA:   if (w_bit_done && (r_bit_cnt == LAST_BIT)) w_state_nxt = S_PARITY;
            S_PARITY: if (w_bit_done) w_state_nxt = S_STOP;
            S_STOP:   if (w_bit_done) w_state_nxt = w_fifo_ne ? S_START : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: pop/shift strobes and the next serial level
    always_comb begin
        w_pop      = 1'b0;
        w_shift_en = 1'b0;
        w_tx_nxt   = r_tx;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_fifo_ne) begin
                    w_pop    = 1'b1;
                    w_tx_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_tx_nxt   = r_shift[DATA_W-1];
                    w_shift_en = 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_tx_nxt = r_parity;
                    end else begin
                        w_tx_nxt   = r_shift[DATA_W-1];
                        w_shift_en = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_done) w_tx_nxt = 1'b1;
            end
            S_STOP: begin
                if (w_bit_done) begin
                    if (w_fifo_ne) begin
                        w_pop    = 1'b1;
                        w_tx_nxt = 1'b0;
                    end else begin
                        w_tx_nxt = 1'b1;
                    end
                end
            end
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // FIFO, shift register, bit timing and serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_cnt <= 2'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= bus.g_in;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;

            if (w_pop) begin
                r_shift  <= w_head;
                r_parity <= ^w_head;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            end

            if ((r_state == S_IDLE) || w_bit_done) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + CNT_W'(1);
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= 2'd0;
            end else if (w_bit_done) begin
                r_bit_cnt <= r_bit_cnt + 2'd1;
            end

            r_tx   <= w_tx_nxt;
            r_busy <= (w_count_nxt != 2'd0) || (w_state_nxt != S_IDLE);
        end
    end

    // Gray step checker, independent of the serializer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_step_err <= w_step_bad;
            if (w_push) begin
                r_prev      <= bus.g_in;
                r_have_prev <= 1'b1;
            end
            if (w_step_bad && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.g_ready   = w_ready;
    assign bus.tx        = r_tx;
    assign bus.busy      = r_busy;
    assign bus.step_err  = r_step_err;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_gray_tx.sv
// Scoreboard bench for gray_tx: expected frames/step flags are queued at acceptance
// and compared when the serial line delivers a complete frame.
module tb_gray_tx;
    localparam int unsigned CPB     = 4;
    localparam int unsigned BOUND   = 3000;

    logic clk;
    logic rst;

    gray_tx_if if4 ();
    gray_tx_if if1 ();

    gray_tx #(.CLKS_PER_BIT(CPB)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    gray_tx #(.CLKS_PER_BIT(1))   dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [27:0] q4 [$];
    logic [27:0] q1 [$];
    int          starts [$];
    bit          rec_starts;
    bit          m_have;
    logic [3:0]  m_prev;
    logic [7:0]  m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Line levels of one frame, each repeated cpb times, oldest sample in the MSBs.
    function automatic logic [27:0] exp_frame(input logic [3:0] w, input int cpb);
        logic [6:0]  lv;
        logic [27:0] v;
        lv = {1'b0, w, ^w, 1'b1};
        v  = '0;
        for (int b = 6; b >= 0; b--)
            for (int k = 0; k < cpb; k++)
                v = {v[26:0], lv[b]};
        return v;
    endfunction

    // Frame monitor for the CLKS_PER_BIT=4 instance
    initial begin
        bit          act;
        int          n;
        logic [27:0] bits;
        act = 0; n = 0; bits = '0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                act = 0;
            end else begin
                if (!act && if4.tx == 1'b0) begin
                    act = 1; n = 0; bits = '0;
                    if (rec_starts) starts.push_back(cyc);
                end
                if (act) begin
                    bits = {bits[26:0], if4.tx};
                    n++;
                    if (n == 7 * CPB) begin
                        act = 0;
                        if (q4.size() == 0) check_eq("frame4_unexpected", 32'(q4.size()), 32'd1);
                        else                check_eq("frame4", 32'(bits), 32'(q4.pop_front()));
                    end
                end
            end
        end
    end

    // Frame monitor for the CLKS_PER_BIT=1 instance
    initial begin
        bit          act;
        int          n;
        logic [27:0] bits;
        act = 0; n = 0; bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0;
            end else begin
                if (!act && if1.tx == 1'b0) begin
                    act = 1; n = 0; bits = '0;
                end
                if (act) begin
                    bits = {bits[26:0], if1.tx};
                    n++;
                    if (n == 7) begin
                        act = 0;
                        if (q1.size() == 0) check_eq("frame1_unexpected", 32'(q1.size()), 32'd1);
                        else                check_eq("frame1", 32'(bits), 32'(q1.pop_front()));
                    end
                end
            end
        end
    end

    // Offer one word (entered at a negedge) and check the step flag after acceptance.
    task automatic send4(input logic [3:0] w);
        int   t;
        logic e;
        t = 0;
        if4.g_in    = w;
        if4.g_valid = 1'b1;
        while (!if4.g_ready && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        if (t >= BOUND) begin
            check_eq("ready_timeout", 32'(if4.g_ready), 32'd1);
            if4.g_valid = 1'b0;
            return;
        end
        e = m_have && ($countones(w ^ m_prev) != 1);
        if (e && m_cnt != 8'hFF) m_cnt++;
        m_have = 1;
        m_prev = w;
        q4.push_back(exp_frame(w, CPB));
        @(negedge clk);
        if4.g_valid = 1'b0;
        check_eq("step_err", 32'(if4.step_err), 32'(e));
        check_eq("err_count", 32'(if4.err_count), 32'(m_cnt));
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((q4.size() != 0 || q1.size() != 0 || if4.busy) && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_drain_timeout"}, 32'(t < BOUND), 32'd1);
        check_eq({tag, "_tx_idle"}, 32'(if4.tx), 32'd1);
        check_eq({tag, "_busy_idle"}, 32'(if4.busy), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_tx"}, 32'(if4.tx), 32'd1);
        check_eq({tag, "_busy"}, 32'(if4.busy), 32'd0);
        check_eq({tag, "_step_err"}, 32'(if4.step_err), 32'd0);
        check_eq({tag, "_err_count"}, 32'(if4.err_count), 32'd0);
        check_eq({tag, "_ready"}, 32'(if4.g_ready), 32'd1);
    endtask

    // Assert reset away from the sampling edge; checks the async effect right away.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 rst = 1'b1;
        q4.delete();
        q1.delete();
        m_have = 0;
        m_cnt  = 8'd0;
        #1 check_reset_state(tag);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ready_after"}, 32'(if4.g_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        n_checks = 0; n_fail = 0;
        rec_starts = 0; m_have = 0; m_prev = '0; m_cnt = 8'd0;
        if4.g_in = '0; if4.g_valid = 1'b0;
        if1.g_in = '0; if1.g_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_state("por");
        check_eq("por_tx1", 32'(if1.tx), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_por", 32'(if4.g_ready), 32'd1);

        // One-cycle bit period: 1011 -> 0,1,0,1,1,1,1
        if1.g_in    = 4'b1011;
        if1.g_valid = 1'b1;
        q1.push_back(exp_frame(4'b1011, 1));
        @(negedge clk);
        if1.g_valid = 1'b0;

        // Single frame on an idle line
        send4(4'b0110);
        drain("single");

        // Three words offered back to back: third fills the FIFO, frames have no gap
        rec_starts = 1;
        send4(4'b0001);
        send4(4'b0011);
        send4(4'b0010);
        check_eq("b2b_ready_full", 32'(if4.g_ready), 32'd0);
        check_eq("b2b_busy", 32'(if4.busy), 32'd1);
        drain("b2b");
        rec_starts = 0;
        check_eq("b2b_nstarts", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            check_eq("b2b_gap01", 32'(starts[1] - starts[0]), 32'(7 * CPB));
            check_eq("b2b_gap12", 32'(starts[2] - starts[1]), 32'(7 * CPB));
        end

        // Step checking: distance 2 and distance 0 are both flagged
        do_reset("rst_a");
        send4(4'b0000);
        send4(4'b0001);
        send4(4'b0111);
        send4(4'b0111);
        check_eq("err_count_two", 32'(if4.err_count), 32'd2);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) send4(4'b0101);
        drain("sat");
        check_eq("err_count_sat", 32'(if4.err_count), 32'd255);

        // Reset during DATA aborts the frame; the next word is a clean first word
        send4(4'b1001);
        repeat (7) @(negedge clk);
        check_eq("pre_abort_busy", 32'(if4.busy), 32'd1);
        do_reset("rst_mid");
        send4(4'b1000);
        send4(4'b0000);
        send4(4'b1000);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
